// File: rtl/bsg_tag_serializer.sv
// Serializes tag packets (start, length, data-not-reset, node id, payload) and
// master-reset ones bursts onto a one-bit tag line. Each is followed by an idle gap.
`timescale 1ns/1ps
module bsg_tag_serializer #(
  parameter int els_p               = 64,
  parameter int lg_width_p          = 9,
  parameter int max_payload_width_p = 128,
  parameter int gap_cycles_p        = 4,
  parameter int reset_ones_p        = 64,
  localparam int lg_els_lp          = $clog2(els_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic                           master_reset_i,
  input  logic [lg_els_lp-1:0]           nodeid_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_p-1:0]          len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           tag_data_o,
  output logic                           tag_en_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int frame_w_lp  = lg_width_p + 1 + lg_els_lp + max_payload_width_p;
  localparam int len_span_lp = 1 << lg_width_p;
  localparam int cnt_a_lp    = (reset_ones_p > len_span_lp) ? reset_ones_p : len_span_lp;
  localparam int cnt_max_lp  = (cnt_a_lp > gap_cycles_p) ? cnt_a_lp : gap_cycles_p;
  localparam int cnt_w_lp    = $clog2(cnt_max_lp + 1);

  typedef logic [cnt_w_lp-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE, RST_ONES, START, LEN, DNR, ID, PAYLOAD, GAP
  } state_e;

  state_e                  state_r, state_n;
  cnt_t                    cnt_r, cnt_n;
  logic [frame_w_lp-1:0]   sr_r;
  logic [lg_width_p-1:0]   len_r;
  logic                    ready_r, err_r, data_r;
  logic                    accept, len_bad, last, shift, data_n, err_n;

  assign accept  = v_i & ready_r;
  assign len_bad = len_i > (lg_width_p)'(max_payload_width_p);
  assign last    = (cnt_r == '0);

  // The cycle-by-cycle frame after the start bit is just the shift register
  // read LSB-first: len, then data_not_reset, then node id, then payload.
  assign shift = state_n inside {LEN, DNR, ID, PAYLOAD};

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    err_n   = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (accept) begin
          if (master_reset_i) begin
            state_n = RST_ONES;
            cnt_n   = cnt_t'(reset_ones_p - 1);
          end else if (len_bad) begin
            err_n = 1'b1;
          end else begin
            state_n = START;
            cnt_n   = '0;
          end
        end
      end
      RST_ONES, PAYLOAD: begin
        if (last) begin
          state_n = GAP;
          cnt_n   = cnt_t'(gap_cycles_p - 1);
        end else begin
          cnt_n = cnt_r - cnt_t'(1);
        end
      end
      START: begin
        state_n = LEN;
        cnt_n   = cnt_t'(lg_width_p - 1);
      end
      LEN: begin
        if (last) state_n = DNR;
        else      cnt_n   = cnt_r - cnt_t'(1);
      end
      DNR: begin
        state_n = ID;
        cnt_n   = cnt_t'(lg_els_lp - 1);
      end
      ID: begin
        if (!last) begin
          cnt_n = cnt_r - cnt_t'(1);
        end else if (len_r == '0) begin
          state_n = GAP;
          cnt_n   = cnt_t'(gap_cycles_p - 1);
        end else begin
          state_n = PAYLOAD;
          cnt_n   = cnt_t'(len_r) - cnt_t'(1);
        end
      end
      GAP: begin
        if (last) state_n = IDLE;
        else      cnt_n   = cnt_r - cnt_t'(1);
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    data_n = shift ? sr_r[0] : (state_n inside {START, RST_ONES});
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      sr_r    <= '0;
      len_r   <= '0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      data_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      ready_r <= (state_n == IDLE);
      err_r   <= err_n;
      data_r  <= data_n;
      if (accept) begin
        sr_r  <= {payload_i, nodeid_i, data_not_reset_i, len_i};
        len_r <= len_i;
      end else if (shift) begin
        sr_r  <= sr_r >> 1;
      end
    end
  end

  assign ready_o    = ready_r;
  assign tag_data_o = data_r;
  assign tag_en_o   = state_r inside {RST_ONES, START, LEN, DNR, ID, PAYLOAD};
  assign done_o     = (state_r == GAP) && last;
  assign err_o      = err_r;

endmodule

// File: tb/tb_bsg_tag_serializer.sv
// Directed bench for bsg_tag_serializer with default parameters: hand-computed
// frames, master reset burst, length error, mid-packet reset and back-to-back.
`timescale 1ns/1ps
module tb_bsg_tag_serializer;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         v_i;
  logic         ready_o;
  logic         master_reset_i;
  logic [6:0]   nodeid_i;
  logic         data_not_reset_i;
  logic [8:0]   len_i;
  logic [127:0] payload_i;
  logic         tag_data_o;
  logic         tag_en_o;
  logic         done_o;
  logic         err_o;

  int checks   = 0;
  int failures = 0;

  bsg_tag_serializer dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .v_i              (v_i),
    .ready_o          (ready_o),
    .master_reset_i   (master_reset_i),
    .nodeid_i         (nodeid_i),
    .data_not_reset_i (data_not_reset_i),
    .len_i            (len_i),
    .payload_i        (payload_i),
    .tag_data_o       (tag_data_o),
    .tag_en_o         (tag_en_o),
    .done_o           (done_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic request(input logic mr, input logic [6:0] id, input logic dnr,
                         input logic [8:0] len, input logic [127:0] pl);
    v_i              = 1'b1;
    master_reset_i   = mr;
    nodeid_i         = id;
    data_not_reset_i = dnr;
    len_i            = len;
    payload_i        = pl;
  endtask

  // Called in cycle 1 after acceptance; returns in the cycle after done_o.
  task automatic run_frame(output logic [63:0] bits, output int n_en, output int first_en,
                           output int last_en, output int done_at, output int done_cnt,
                           output logic ready_busy, output logic ready_after, output logic stray);
    bits = '0; n_en = 0; first_en = -1; last_en = -1; done_at = -1; done_cnt = 0;
    ready_busy = 1'b0; ready_after = 1'b0; stray = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (done_at >= 0) begin
        ready_after = ready_o;
        break;
      end
      if (tag_en_o === 1'b1) begin
        if (n_en < 64) bits[n_en] = tag_data_o;
        n_en++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end else if (tag_data_o !== 1'b0) begin
        stray = 1'b1;
      end
      if (ready_o !== 1'b0) ready_busy = 1'b1;
      if (done_o === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      tick();
    end
  endtask

  logic [63:0] bits, bits_a;
  int          n_en, first_en, last_en, done_at, done_cnt;
  int          last_a, done_a;
  logic        ready_busy, ready_after, stray;
  int          seen_en, seen_done;

  initial begin
    reset_n_i = 1'b0;
    v_i = 1'b0; master_reset_i = 1'b0; nodeid_i = '0;
    data_not_reset_i = 1'b0; len_i = '0; payload_i = '0;

    repeat (3) tick();
    check("rst_ready", ready_o, 0);
    check("rst_data", tag_data_o, 0);
    check("rst_en", tag_en_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    #2 reset_n_i = 1'b1;
    #1 check("ready_before_edge", ready_o, 0);
    tick();
    check("ready_after_rst", ready_o, 1);

    // Data packet: nodeid 5, dnr 1, len 3, payload 101; later input changes ignored
    request(1'b0, 7'd5, 1'b1, 9'd3, 128'b101);
    tick();
    v_i = 1'b0; payload_i = '1; len_i = 9'd7; nodeid_i = 7'd0;
    check("p1_busy_ready", ready_o, 0);
    run_frame(bits, n_en, first_en, last_en, done_at, done_cnt, ready_busy, ready_after, stray);
    check("p1_bits", bits, 64'(21'b101_0000101_1_000000011_1));
    check("p1_en_cycles", n_en, 21);
    check("p1_first", first_en, 1);
    check("p1_last", last_en, 21);
    check("p1_done_at", done_at, 25);
    check("p1_done_cnt", done_cnt, 1);
    check("p1_ready_busy", ready_busy, 0);
    check("p1_ready_after", ready_after, 1);
    check("p1_gap_zero", stray, 0);

    // Master reset burst, length field out of range must be ignored
    request(1'b1, 7'h55, 1'b0, 9'd200, '0);
    tick();
    v_i = 1'b0;
    check("mr_no_err", err_o, 0);
    run_frame(bits, n_en, first_en, last_en, done_at, done_cnt, ready_busy, ready_after, stray);
    check("mr_bits", bits, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mr_en_cycles", n_en, 64);
    check("mr_done_at", done_at, 68);
    check("mr_gap_zero", stray, 0);
    check("mr_ready_after", ready_after, 1);

    // Zero-length client reset packet
    request(1'b0, 7'd0, 1'b0, 9'd0, '1);
    tick();
    v_i = 1'b0;
    run_frame(bits, n_en, first_en, last_en, done_at, done_cnt, ready_busy, ready_after, stray);
    check("z_bits", bits, 64'h1);
    check("z_en_cycles", n_en, 18);
    check("z_done_at", done_at, 22);
    check("z_ready_busy", ready_busy, 0);
    check("z_ready_after", ready_after, 1);

    // Over-length request rejected
    request(1'b0, 7'd3, 1'b1, 9'd129, '1);
    tick();
    v_i = 1'b0;
    check("err_pulse", err_o, 1);
    check("err_en", tag_en_o, 0);
    check("err_ready", ready_o, 1);
    tick();
    check("err_single", err_o, 0);
    seen_en = 0;
    repeat (5) begin
      if (tag_en_o !== 1'b0 || tag_data_o !== 1'b0) seen_en++;
      tick();
    end
    check("err_silent", seen_en, 0);

    // Maximum legal length is accepted
    request(1'b0, 7'd1, 1'b1, 9'd128, '1);
    tick();
    v_i = 1'b0;
    check("max_no_err", err_o, 0);
    run_frame(bits, n_en, first_en, last_en, done_at, done_cnt, ready_busy, ready_after, stray);
    check("max_en_cycles", n_en, 146);
    check("max_done_at", done_at, 150);

    // Reset during payload bit 2 of a len=100 packet
    request(1'b0, 7'd9, 1'b1, 9'd100, 128'b100);
    tick();
    v_i = 1'b0;
    repeat (20) tick();
    check("mid_en", tag_en_o, 1);
    check("mid_bit2", tag_data_o, 1);
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_data", tag_data_o, 0);
    check("mid_rst_en", tag_en_o, 0);
    check("mid_rst_ready", ready_o, 0);
    repeat (2) tick();
    #2 reset_n_i = 1'b1;
    seen_en = 0; seen_done = 0;
    repeat (40) begin
      tick();
      if (done_o !== 1'b0) seen_done++;
      if (tag_en_o !== 1'b0) seen_en++;
    end
    check("mid_no_done", seen_done, 0);
    check("mid_no_en", seen_en, 0);
    check("mid_ready", ready_o, 1);
    request(1'b0, 7'd2, 1'b0, 9'd2, 128'b10);
    tick();
    v_i = 1'b0;
    run_frame(bits, n_en, first_en, last_en, done_at, done_cnt, ready_busy, ready_after, stray);
    check("post_bits", bits, 64'(20'b10_0000010_0_000000010_1));
    check("post_en_cycles", n_en, 20);
    check("post_done_at", done_at, 24);

    // Back-to-back with v_i held high; inputs switch to the second request mid-packet
    request(1'b0, 7'd3, 1'b1, 9'd4, 128'b0110);
    tick();
    request(1'b0, 7'd100, 1'b0, 9'd1, 128'b1);
    run_frame(bits, n_en, first_en, last_en, done_at, done_cnt, ready_busy, ready_after, stray);
    bits_a = bits; last_a = last_en; done_a = done_at;
    check("bb_a_bits", bits_a, 64'(22'b0110_0000011_1_000000100_1));
    check("bb_a_done_at", done_a, 26);
    check("bb_a_ready_busy", ready_busy, 0);
    check("bb_a_ready_after", ready_after, 1);
    tick();
    v_i = 1'b0;
    run_frame(bits, n_en, first_en, last_en, done_at, done_cnt, ready_busy, ready_after, stray);
    check("bb_b_bits", bits, 64'(19'b1_1100100_0_000000001_1));
    check("bb_b_done_at", done_at, 23);
    check("bb_idle_between", (done_a + 1 + first_en) - last_a - 1, 5);
    tick();
    check("bb_no_third", tag_en_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
